// File: rtl/deflate_stream_packer.sv
// Pairs 256-bit shifter words into 512-bit beats, queues them, and closes the
// stream with a tail beat tagged last plus the total compressed byte count.
module deflate_stream_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             word_valid,
    input  logic [255:0]     word_data,
    input  logic             flush,
    input  logic [511:0]     tail_data,
    input  logic [8:0]       tail_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [511:0]     out_data,
    output logic [6:0]       out_bytes,
    output logic             out_last,
    output logic             almost_full,
    output logic [CNT_W-1:0] total_bytes,
    output logic             done,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_TAIL,
        S_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [255:0]     r_half;
    logic             r_half_vld;
    logic [255:0]     r_tail;
    logic [5:0]       r_tb;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_total;
    logic             r_done;
    logic             r_ovf;
    logic             r_af;

    logic [511:0]     r_mem       [FIFO_DEPTH];
    logic [6:0]       r_mem_bytes [FIFO_DEPTH];
    logic             r_mem_last  [FIFO_DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    logic [AW:0]      w_count;
    logic [AW:0]      w_count_nxt;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_push_ok;
    logic             w_drop;
    logic [511:0]     w_push_data;
    logic [6:0]       w_push_bytes;
    logic             w_push_last;
    logic             w_take_word;
    logic             w_take_flush;
    logic             w_proto_err;
    logic             w_last_pop;
    logic [7:0]       w_tlen;
    logic [255:0]     w_mask;
    logic [255:0]     w_tail;
    logic [5:0]       w_tb;

    assign w_count   = r_wptr - r_rptr;
    assign w_empty   = (w_count == '0);
    assign w_full    = (w_count == (AW+1)'(FIFO_DEPTH));
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && !w_push_ok;

    assign w_count_nxt = w_count + {{AW{1'b0}}, w_push_ok}
                                 - {{AW{1'b0}}, w_pop};

    assign out_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign out_bytes = w_empty ? '0 : r_mem_bytes[r_rptr[AW-1:0]];
    assign out_last  = w_empty ? 1'b0 : r_mem_last[r_rptr[AW-1:0]];

    assign w_last_pop = (r_state == S_DRAIN) && w_pop && out_last;

    // Residual length saturates at 255 so bit 255 of the tail is never kept
    assign w_tlen = (tail_len > 9'd255) ? 8'd255 : tail_len[7:0];
    assign w_mask = (256'd1 << w_tlen) - 256'd1;
    assign w_tail = tail_data[255:0] & w_mask;
    assign w_tb   = 6'(({1'b0, w_tlen} + 9'd7) >> 3);

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_push_data  = '0;
        w_push_bytes = '0;
        w_push_last  = 1'b0;
        w_take_word  = 1'b0;
        w_take_flush = 1'b0;
        w_proto_err  = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_take_word  = word_valid;
                w_take_flush = flush;
                if (word_valid && r_half_vld) begin
                    w_push       = 1'b1;
                    w_push_data  = {word_data, r_half};
                    w_push_bytes = 7'd64;
                end
                if (flush)
                    w_state_nxt = S_TAIL;
            end
            S_TAIL: begin
                w_proto_err = word_valid || flush;
                // Wait for room rather than dropping the closing beat
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_push_last = 1'b1;
                    w_state_nxt = S_DRAIN;
                    if (r_half_vld) begin
                        w_push_data  = {r_tail, r_half};
                        w_push_bytes = 7'd32 + {1'b0, r_tb};
                    end else begin
                        w_push_data  = {256'd0, r_tail};
                        w_push_bytes = {1'b0, r_tb};
                    end
                end
            end
            S_DRAIN: begin
                w_proto_err = word_valid || flush;
                if (w_last_pop)
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_half     <= '0;
            r_half_vld <= 1'b0;
            r_tail     <= '0;
            r_tb       <= '0;
            r_cnt      <= '0;
            r_total    <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_af       <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last_pop;
            r_af    <= (w_count_nxt >= (AW+1)'(FIFO_DEPTH - 2));
            if (w_drop || w_proto_err)
                r_ovf <= 1'b1;
            if (w_push_ok)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_take_word) begin
                if (r_half_vld) begin
                    r_half_vld <= 1'b0;
                end else begin
                    r_half     <= word_data;
                    r_half_vld <= 1'b1;
                end
            end
            if (w_take_flush) begin
                r_tail <= w_tail;
                r_tb   <= w_tb;
            end
            if (w_last_pop) begin
                r_total    <= r_cnt;
                r_cnt      <= '0;
                r_half_vld <= 1'b0;
            end else begin
                r_cnt <= r_cnt
                       + (w_take_word  ? CNT_W'(32) : '0)
                       + (w_take_flush ? CNT_W'(w_tb) : '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]]       <= w_push_data;
            r_mem_bytes[r_wptr[AW-1:0]] <= w_push_bytes;
            r_mem_last[r_wptr[AW-1:0]]  <= w_push_last;
        end
    end

    assign almost_full = r_af;
    assign total_bytes = r_total;
    assign done        = r_done;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_deflate_stream_packer.sv
// Directed bench for deflate_stream_packer: pairing, tail beat, backpressure,
// overflow, same-cycle word/flush, and reset in the middle of a drain.
module tb_deflate_stream_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         word_valid;
    logic [255:0] word_data;
    logic         flush;
    logic [511:0] tail_data;
    logic [8:0]   tail_len;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic [6:0]   out_bytes;
    logic         out_last;
    logic         almost_full;
    logic [31:0]  total_bytes;
    logic         done;
    logic         overflow;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;

    logic [511:0] q_data [$];
    logic [6:0]   q_bytes[$];
    logic         q_last [$];

    deflate_stream_packer #(.FIFO_DEPTH(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .word_valid(word_valid), .word_data(word_data),
        .flush(flush), .tail_data(tail_data), .tail_len(tail_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_bytes(out_bytes), .out_last(out_last),
        .almost_full(almost_full), .total_bytes(total_bytes),
        .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_bytes.push_back(out_bytes);
                q_last.push_back(out_last);
            end
            if (done)
                done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] wd(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic send_word(input logic [255:0] w);
        word_valid = 1'b1;
        word_data  = w;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic do_flush(input logic [8:0] len, input logic [511:0] td);
        flush     = 1'b1;
        tail_len  = len;
        tail_data = td;
        tick();
        flush     = 1'b0;
        tail_data = {512{1'b1}};
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 200 && done_cnt == 0; k++)
            tick();
        chk({tag, "_done_seen"}, 512'(done_cnt > 0), 512'(1));
        repeat (4) tick();
        chk({tag, "_done_once"}, 512'(done_cnt), 512'(1));
    endtask

    task automatic beat(input string tag, input int k, input logic [511:0] d,
                        input logic [6:0] b, input logic l);
        if (k < q_data.size()) begin
            chk({tag, "_data"}, q_data[k], d);
            chk({tag, "_bytes"}, 512'(q_bytes[k]), 512'(b));
            chk({tag, "_last"}, 512'(q_last[k]), 512'(l));
        end else begin
            chk({tag, "_missing"}, 512'(q_data.size()), 512'(k + 1));
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_bytes.delete();
        q_last.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_q();
    endtask

    initial begin
        logic [511:0] td;
        reset      = 1'b1;
        word_valid = 1'b0;
        word_data  = '0;
        flush      = 1'b0;
        tail_data  = {512{1'b1}};
        tail_len   = '0;
        out_ready  = 1'b0;
        do_reset();

        chk("rst_valid", 512'(out_valid), 512'(0));
        chk("rst_last", 512'(out_last), 512'(0));
        chk("rst_bytes", 512'(out_bytes), 512'(0));
        chk("rst_data", out_data, 512'(0));
        chk("rst_af", 512'(almost_full), 512'(0));
        chk("rst_total", 512'(total_bytes), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_ovf", 512'(overflow), 512'(0));

        // four words, empty tail -> marker beat
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++)
            send_word(wd(i));
        do_flush(9'd0, {512{1'b1}});
        wait_done("t1");
        chk("t1_n", 512'(q_data.size()), 512'(3));
        beat("t1_b0", 0, {wd(2), wd(1)}, 7'd64, 1'b0);
        beat("t1_b1", 1, {wd(4), wd(3)}, 7'd64, 1'b0);
        beat("t1_b2", 2, 512'd0, 7'd0, 1'b1);
        chk("t1_total", 512'(total_bytes), 512'(128));
        chk("t1_ovf", 512'(overflow), 512'(0));

        // three words, 13-bit tail with garbage above
        clear_q();
        for (int i = 11; i <= 13; i++)
            send_word(wd(i));
        td = {512{1'b1}};
        td[12:0] = 13'h1ABC;
        do_flush(9'd13, td);
        wait_done("t2");
        chk("t2_n", 512'(q_data.size()), 512'(2));
        beat("t2_b0", 0, {wd(12), wd(11)}, 7'd64, 1'b0);
        beat("t2_b1", 1, {243'd0, 13'h1ABC, wd(13)}, 7'd34, 1'b1);
        chk("t2_total", 512'(total_bytes), 512'(98));

        // backpressure fill, almost_full and overflow
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 34; i++) begin
            send_word(wd(100 + i));
            if (i == 25) chk("t3_af13", 512'(almost_full), 512'(0));
            if (i == 27) chk("t3_af14", 512'(almost_full), 512'(1));
            if (i == 31) chk("t3_ovf16", 512'(overflow), 512'(0));
        end
        chk("t3_ovf17", 512'(overflow), 512'(1));
        do_flush(9'd0, {512{1'b1}});
        out_ready = 1'b1;
        wait_done("t3");
        chk("t3_n", 512'(q_data.size()), 512'(17));
        for (int k = 0; k < 16; k++)
            beat($sformatf("t3_b%0d", k), k,
                 {wd(101 + 2 * k), wd(100 + 2 * k)}, 7'd64, 1'b0);
        beat("t3_b16", 16, 512'd0, 7'd0, 1'b1);
        chk("t3_ovf_sticky", 512'(overflow), 512'(1));

        // word and flush in one cycle with a pending half
        do_reset();
        out_ready = 1'b1;
        send_word(wd(21));
        td = {512{1'b1}};
        td[7:0] = 8'h5A;
        word_valid = 1'b1;
        word_data  = wd(22);
        do_flush(9'd8, td);
        word_valid = 1'b0;
        wait_done("t4");
        chk("t4_n", 512'(q_data.size()), 512'(2));
        beat("t4_b0", 0, {wd(22), wd(21)}, 7'd64, 1'b0);
        beat("t4_b1", 1, {248'd0, 8'h5A, 256'd0} >> 256, 7'd1, 1'b1);
        chk("t4_total", 512'(total_bytes), 512'(65));
        chk("t4_ovf", 512'(overflow), 512'(0));

        // flush into a full FIFO must stall, not overflow
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++)
            send_word(wd(200 + i));
        td = {512{1'b1}};
        td[15:0] = 16'hBEEF;
        do_flush(9'd16, td);
        repeat (5) tick();
        chk("t5_ovf_stall", 512'(overflow), 512'(0));
        chk("t5_valid", 512'(out_valid), 512'(1));
        chk("t5_hold_last", 512'(out_last), 512'(0));
        out_ready = 1'b1;
        wait_done("t5");
        chk("t5_n", 512'(q_data.size()), 512'(17));
        beat("t5_b0", 0, {wd(201), wd(200)}, 7'd64, 1'b0);
        beat("t5_b15", 15, {wd(231), wd(230)}, 7'd64, 1'b0);
        beat("t5_b16", 16, {496'd0, 16'hBEEF}, 7'd2, 1'b1);
        chk("t5_total", 512'(total_bytes), 512'(1026));
        chk("t5_ovf", 512'(overflow), 512'(0));

        // reset in DRAIN with beats queued
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send_word(wd(300 + i));
        do_flush(9'd0, {512{1'b1}});
        repeat (3) tick();
        send_word(wd(399));
        chk("t6_ovf_proto", 512'(overflow), 512'(1));
        chk("t6_valid_pre", 512'(out_valid), 512'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_valid", 512'(out_valid), 512'(0));
        chk("t6_ovf", 512'(overflow), 512'(0));
        chk("t6_total", 512'(total_bytes), 512'(0));
        chk("t6_af", 512'(almost_full), 512'(0));
        out_ready = 1'b1;
        repeat (6) tick();
        chk("t6_no_done", 512'(done_cnt), 512'(0));
        chk("t6_no_beats", 512'(q_data.size()), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
